// File: rtl/gear_pkg.sv
// Shared constants and helpers for the gear selector: widths, blank code,
// scan state encoding and binary-to-BCD digit extraction.
package gear_pkg;

  localparam int GEAR_W           = 7;
  localparam int DEFAULT_MAX_GEAR = 22;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [0:0] S_ONES = 1'b0;
  localparam logic [0:0] S_TENS = 1'b1;

  // Gear never exceeds 99, so both digits always fit in 0..9.
  function automatic logic [3:0] gear_ones(input logic [GEAR_W-1:0] g);
    return 4'(g % 7'd10);
  endfunction

  function automatic logic [3:0] gear_tens(input logic [GEAR_W-1:0] g);
    return 4'(g / 7'd10);
  endfunction

endpackage

// File: rtl/gear_counter_debouncer.sv
// Two-flop synchronizer plus stable-level debouncer for one raw button.
// rise pulses for one cycle in the same cycle the accepted level goes high.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gear_counter.sv
// Saturating gear selector driven by two debounced buttons, with a
// two-digit multiplexed BCD display scanner (tens digit blanked when zero).
module gear_counter
  import gear_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_GEAR        = DEFAULT_MAX_GEAR,
  parameter int SCAN_DIV        = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_up,
  input  logic              shift_down,
  output logic [GEAR_W-1:0] gear,
  output logic              gear_changed,
  output logic [3:0]        bcd_out,
  output logic [1:0]        an
);

  localparam logic [GEAR_W-1:0] MAX_G = GEAR_W'(MAX_GEAR);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic level_up, rise_up, level_dn, rise_dn;
  logic up_req, dn_req;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (shift_up),
    .level (level_up),
    .rise  (rise_up)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk   (clk),
    .reset (reset),
    .raw   (shift_down),
    .level (level_dn),
    .rise  (rise_dn)
  );

  // A step is only taken on the cycle the accepted level has just risen.
  assign up_req = rise_up & level_up;
  assign dn_req = rise_dn & level_dn;

  always_ff @(posedge clk) begin
    if (reset) begin
      gear         <= GEAR_W'(1);
      gear_changed <= 1'b0;
    end else begin
      gear_changed <= 1'b0;
      if (up_req && !dn_req && gear < MAX_G) begin
        gear         <= gear + GEAR_W'(1);
        gear_changed <= 1'b1;
      end else if (dn_req && !up_req && gear > GEAR_W'(1)) begin
        gear         <= gear - GEAR_W'(1);
        gear_changed <= 1'b1;
      end
    end
  end

  logic [3:0] ones;
  logic [3:0] tens;

  always_ff @(posedge clk) begin
    if (reset) begin
      ones <= 4'd1;
      tens <= 4'd0;
    end else begin
      ones <= gear_ones(gear);
      tens <= gear_tens(gear);
    end
  end

  logic [DW-1:0] div;
  logic [0:0]    scan_state;
  logic [0:0]    scan_next;

  always_comb begin
    scan_next = scan_state;
    if (div == DIV_LAST) scan_next = ~scan_state;
  end

  // an and bcd_out are both decoded from scan_next so they switch together.
  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      scan_state <= S_ONES;
      an         <= 2'b10;
      bcd_out    <= 4'd1;
    end else begin
      div        <= (div == DIV_LAST) ? '0 : div + DW'(1);
      scan_state <= scan_next;
      if (scan_next == S_ONES) begin
        an      <= 2'b10;
        bcd_out <= ones;
      end else begin
        an      <= 2'b01;
        bcd_out <= (tens == 4'd0) ? BLANK_CODE : tens;
      end
    end
  end

endmodule

// File: tb/tb_gear_counter.sv
// Directed bench for gear_counter with DEBOUNCE_CYCLES=4, SCAN_DIV=3, MAX_GEAR=22.
module tb_gear_counter;

  localparam int DEB  = 4;
  localparam int SCAN = 3;
  localparam int MAXG = 22;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shift_up = 1'b0;
  logic       shift_down = 1'b0;
  logic [6:0] gear;
  logic       gear_changed;
  logic [3:0] bcd_out;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  gear_counter #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_GEAR       (MAXG),
    .SCAN_DIV       (SCAN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .shift_up     (shift_up),
    .shift_down   (shift_down),
    .gear         (gear),
    .gear_changed (gear_changed),
    .bcd_out      (bcd_out),
    .an           (an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (gear_changed) pulses++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit up, input int n);
    for (int i = 0; i < n; i++) begin
      if (up) shift_up = 1'b1;
      else    shift_down = 1'b1;
      repeat (10) tick();
      shift_up   = 1'b0;
      shift_down = 1'b0;
      repeat (10) tick();
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic show(input logic [1:0] want_an, input logic [3:0] want_bcd, input string tag);
    int i;
    i = 0;
    while (an !== want_an && i < 10) begin
      tick();
      i++;
    end
    chk({tag, "_an"}, 32'(an), 32'(want_an));
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(want_bcd));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] e_an;
    logic [3:0] e_bcd;
    int glitch [5];
    glitch = '{1, 0, 1, 1, 0};

    // Scenario 1: reset values, idle scan pattern
    do_reset();
    p0 = pulses;
    chk("rst_gear", 32'(gear), 32'd1);
    chk("rst_changed", 32'(gear_changed), 32'd0);
    chk("rst_an", 32'(an), 32'h2);
    chk("rst_bcd", 32'(bcd_out), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      e_an  = (((k / 3) % 2) == 1) ? 2'b01 : 2'b10;
      e_bcd = (((k / 3) % 2) == 1) ? 4'hF : 4'd1;
      chk("idle_an", 32'(an), 32'(e_an));
      chk("idle_bcd", 32'(bcd_out), 32'(e_bcd));
    end
    chk("idle_gear", 32'(gear), 32'd1);
    chk("idle_pulses", 32'(pulses - p0), 32'd0);

    // Scenario 2: clean press, 7-cycle latency, no repeat while held
    p0 = pulses;
    shift_up = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("lat_pre_gear", 32'(gear), 32'd1);
    end
    tick();
    chk("lat_gear", 32'(gear), 32'd2);
    chk("lat_changed", 32'(gear_changed), 32'd1);
    tick();
    chk("lat_changed_end", 32'(gear_changed), 32'd0);
    repeat (2) tick();
    shift_up = 1'b0;
    repeat (12) tick();
    chk("held_gear", 32'(gear), 32'd2);
    chk("held_pulses", 32'(pulses - p0), 32'd1);

    // Scenario 3: glitches, then stable high
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      shift_up = glitch[i][0];
      tick();
    end
    shift_up = 1'b1;
    repeat (6) tick();
    chk("glitch_pre_gear", 32'(gear), 32'd2);
    chk("glitch_pre_pulses", 32'(pulses - p0), 32'd0);
    tick();
    chk("glitch_gear", 32'(gear), 32'd3);
    chk("glitch_changed", 32'(gear_changed), 32'd1);
    repeat (3) tick();
    shift_up = 1'b0;
    repeat (12) tick();
    chk("glitch_pulses", 32'(pulses - p0), 32'd1);

    // Scenario 4: saturate at MAX_GEAR and at 1
    do_reset();
    p0 = pulses;
    press(1'b1, 25);
    chk("max_gear", 32'(gear), 32'd22);
    chk("max_pulses", 32'(pulses - p0), 32'd21);
    show(2'b01, 4'd2, "tens22");
    show(2'b10, 4'd2, "ones22");
    press(1'b0, 30);
    chk("min_gear", 32'(gear), 32'd1);
    chk("min_pulses", 32'(pulses - p0), 32'd42);

    // Scenario 5: simultaneous up and down cancel
    press(1'b1, 1);
    chk("pre_both_gear", 32'(gear), 32'd2);
    p0 = pulses;
    shift_up   = 1'b1;
    shift_down = 1'b1;
    repeat (10) tick();
    shift_up   = 1'b0;
    shift_down = 1'b0;
    repeat (12) tick();
    chk("both_gear", 32'(gear), 32'd2);
    chk("both_pulses", 32'(pulses - p0), 32'd0);

    // Scenario 6: 9 -> 10 digit rollover, then reset mid-debounce
    press(1'b1, 7);
    chk("gear9", 32'(gear), 32'd9);
    show(2'b01, 4'hF, "blank9");
    show(2'b10, 4'd9, "ones9");
    press(1'b1, 1);
    chk("gear10", 32'(gear), 32'd10);
    show(2'b01, 4'd1, "tens10");
    show(2'b10, 4'd0, "ones10");
    shift_up = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_gear", 32'(gear), 32'd1);
    chk("mid_rst_changed", 32'(gear_changed), 32'd0);
    chk("mid_rst_an", 32'(an), 32'h2);
    chk("mid_rst_bcd", 32'(bcd_out), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rel_pre_gear", 32'(gear), 32'd1);
    end
    tick();
    chk("rel_gear", 32'(gear), 32'd2);
    shift_up = 1'b0;
    repeat (12) tick();
    chk("rel_final_gear", 32'(gear), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gear_counter.md
GEAR_COUNTER -- requirements
Module: gear_counter

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 500000 and set the stable-level cycles required to accept a button change; legal range is 2 or more.
REQ-002 The parameter MAX_GEAR SHALL default to 22 and set the highest selectable gear; legal range is 1..99.
REQ-003 The parameter SCAN_DIV SHALL default to 50000 and set the clk cycles each display digit is driven; legal range is 1 or more.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 shift_up  input  1  raw, asynchronous, bouncing shift-up button, active-high.
REQ-007 shift_down  input  1  raw, asynchronous, bouncing shift-down button, active-high.
REQ-008 gear  output  7  current gear in binary, 1..MAX_GEAR.
REQ-009 gear_changed  output  1  one-cycle pulse in the cycle gear takes a new value.
REQ-010 bcd_out  output  4  BCD code for the currently scanned digit; feeds the 7-segment decoder; 4'hF blanks the digit.
REQ-011 an  output  2  digit enables, active-low: an[0] is the ones digit, an[1] is the tens digit.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each debouncer SHALL accept a new level only after the synchronized input differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles; any reversion within that window clears its counter.
REQ-014 An accepted 0->1 transition SHALL create exactly one step request; accepted 1->0 transitions and held levels SHALL create none, so there is no auto-repeat.
REQ-015 The latency from a clean raw edge to the gear update SHALL be 2 sync cycles plus DEBOUNCE_CYCLES plus 1 cycles.
REQ-016 An up request SHALL increment gear; at MAX_GEAR it SHALL saturate, with no wrap and no gear_changed pulse.
REQ-017 A down request SHALL decrement gear; at 1 it SHALL saturate, with no wrap and no gear_changed pulse.
REQ-018 Up and down requests in the same cycle SHALL cancel, leaving gear unchanged with no pulse.
REQ-019 The ones and tens BCD digit registers SHALL be updated one cycle after gear changes; only legal values 0..9 are produced.
REQ-020 The scan FSM SHALL have two states, S_ONES and S_TENS, and SHALL toggle between them every SCAN_DIV cycles using a divider counter that wraps from SCAN_DIV-1 to 0.
REQ-021 In S_ONES, an SHALL be 2'b10 and bcd_out SHALL be the ones digit.
REQ-022 In S_TENS, an SHALL be 2'b01 and bcd_out SHALL be the tens digit, or 4'hF when the tens digit is 0 (leading-zero blank).
REQ-023 an and bcd_out SHALL be registered and SHALL change in the same cycle, so a digit is never shown with the other digit's code.
REQ-024 A gear change SHALL NOT reset the scan divider or the scan state.

Reset
REQ-025 While reset is high, the following SHALL hold on the next clk edge:
- gear = 1;
- gear_changed = 0;
- ones digit = 1 and tens digit = 0;
- scan state = S_ONES, an = 2'b10, bcd_out = 4'd1;
- scan divider = 0;
- synchronizers, debouncer counters and accepted levels = 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count.
REQ-027 A button held across reset release SHALL be treated as a new press and SHALL produce one step after the REQ-015 latency.

Structure
REQ-028 The package gear_pkg SHALL hold:
- the default MAX_GEAR;
- the BLANK_CODE 4'hF;
- the scan state encoding S_ONES / S_TENS;
- the gear width 7.
REQ-029 Synchronizer and debouncer SHALL form one sub-module, debouncer, with ports clk, reset, raw, level, rise; it is instantiated twice.

Verification
REQ-030 All scenarios SHALL run with DEBOUNCE_CYCLES=4, SCAN_DIV=3 and MAX_GEAR=22 unless stated otherwise.
REQ-031 Scenario 1: apply reset, then idle 20 cycles -> gear=1, gear_changed never pulses, an alternates 2'b10/2'b01 every 3 cycles, and bcd_out alternates 1 / 4'hF.
REQ-032 Scenario 2: drive shift_up as a clean pulse held 10 cycles -> gear=2 exactly 7 cycles after the rising edge, one gear_changed pulse, no further step while held.
REQ-033 Scenario 3: drive shift_up with glitches 1,0,1,1,0 cycles, then hold high -> exactly one increment, timed from the start of the final stable high.
REQ-034 Scenario 4: press up 25 times -> gear stops at 22 with 21 gear_changed pulses; the scan shows tens=2 and ones=2; then press down 30 times -> gear stops at 1.
REQ-035 Scenario 5: raise shift_up and shift_down together on the same cycle for 10 cycles -> gear unchanged, no pulse.
REQ-036 Scenario 6: step gear to 9, then press up once -> gear=10; tens shows 1 and ones shows 0 with no blank; assert reset mid-debounce of a later press -> all REQ-025 values hold, and no step occurs until a full new debounce window completes.
